commit_checker: RTL



---
 rtl/commit_checker.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/commit_checker.sv
// commit_checker
//   Retirement checker for the single-cycle RISC-V core. It holds a table of NCHK
//   loadable checkpoints. Each one is matched against the retirement stream and its
//   pass/fail outcome is counted. Per-entry visit counters catch branch loops that
//   never exit.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cfg_we/idx/mode   checkpoint write strobe, entry index and mode
//                     (0 off, 1 RESULT, 2 STORE, 3 GUARD); writes are accepted only in CFG
//   cfg_pc/expect/addr  checkpoint PC, expected Result/WriteData, expected DataAdr
//   start             leave CFG and begin checking
//   ret_*             retirement stream: valid, PC, Result, DataAdr, WriteData, MemWrite
//   running/done/hung state flags
//   pass_cnt/fail_cnt saturating outcome counters
//   first_fail_*      index of the first entry that failed
//   hang_idx          index of the entry that tripped the loop guard
module commit_checker #(
    parameter int XLEN       = 32,
    parameter int NCHK       = 40,
    parameter int LOOP_LIMIT = 16,
    parameter int CNT_W      = 8,
    localparam int IW        = (NCHK > 1) ? $clog2(NCHK) : 1,
    localparam int VW        = $clog2(LOOP_LIMIT + 2)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [1:0]      cfg_mode,
    input  logic [XLEN-1:0] cfg_pc,
    input  logic [XLEN-1:0] cfg_expect,
    input  logic [XLEN-1:0] cfg_addr,
    input  logic            start,
    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_pc,
    input  logic [XLEN-1:0] ret_result,
    input  logic [XLEN-1:0] ret_addr,
    input  logic [XLEN-1:0] ret_wdata,
    input  logic            ret_mem_we,
    output logic            running,
    output logic            done,
    output logic            hung,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic            first_fail_valid,
    output logic [IW-1:0]   first_fail_idx,
    output logic [IW-1:0]   hang_idx
);

    typedef enum logic [1:0] {S_CFG, S_RUN, S_DONE, S_HUNG} state_e;

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_RESULT = 2'd1;
    localparam logic [1:0] M_STORE  = 2'd2;

    state_e            state_q, state_d;
    logic [1:0]        mode_q    [NCHK];
    logic [1:0]        mode_d    [NCHK];
    logic [XLEN-1:0]   pc_q      [NCHK];
    logic [XLEN-1:0]   expect_q  [NCHK];
    logic [XLEN-1:0]   addr_q    [NCHK];
    logic              checked_q [NCHK];
    logic              checked_d [NCHK];
    logic [VW-1:0]     visit_q   [NCHK];
    logic [VW-1:0]     visit_d   [NCHK];
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic              ffValid_q, ffValid_d;
    logic [IW-1:0]     ffIdx_q, ffIdx_d, hangIdx_q, hangIdx_d;

    logic              hit, hitChecked, allChecked;
    logic [IW-1:0]     hitIdx;
    logic [1:0]        hitMode;
    logic [VW-1:0]     hitVisit, visitInc;
    logic [XLEN-1:0]   hitExpect, hitAddr;
    logic              isHang, doCheck, checkPass;

    // Parallel PC match; scanning from the top down leaves the lowest matching index.
    always_comb begin
        hit        = 1'b0;
        hitIdx     = '0;
        hitMode    = M_OFF;
        hitChecked = 1'b0;
        hitVisit   = '0;
        hitExpect  = '0;
        hitAddr    = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (mode_q[i] != M_OFF && pc_q[i] == ret_pc) begin
                hit        = 1'b1;
                hitIdx     = IW'(i);
                hitMode    = mode_q[i];
                hitChecked = checked_q[i];
                hitVisit   = visit_q[i];
                hitExpect  = expect_q[i];
                hitAddr    = addr_q[i];
            end
        end
    end

    // Completion looks only at registered flags, so done trails the last check by a cycle.
    always_comb begin
        allChecked = 1'b1;
        for (int i = 0; i < NCHK; i++) begin
            if ((mode_q[i] == M_RESULT || mode_q[i] == M_STORE) && !checked_q[i])
                allChecked = 1'b0;
        end
    end

    assign visitInc  = (hitVisit == {VW{1'b1}}) ? hitVisit : hitVisit + VW'(1);
    assign isHang    = hit && (visitInc == VW'(LOOP_LIMIT + 1));
    assign doCheck   = hit && !isHang && !hitChecked &&
                       (hitMode == M_RESULT || hitMode == M_STORE);
    assign checkPass = (hitMode == M_RESULT) ? (ret_result == hitExpect)
                     : (ret_mem_we && ret_addr == hitAddr && ret_wdata == hitExpect);

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffValid_d = ffValid_q;
        ffIdx_d   = ffIdx_q;
        hangIdx_d = hangIdx_q;
        for (int i = 0; i < NCHK; i++) begin
            mode_d[i]    = mode_q[i];
            checked_d[i] = checked_q[i];
            visit_d[i]   = visit_q[i];
        end
        case (state_q)
            S_CFG: begin
                // Indices beyond NCHK never match the loop and are dropped.
                for (int i = 0; i < NCHK; i++) begin
                    if (cfg_we && IW'(i) == cfg_idx) begin
                        mode_d[i]    = cfg_mode;
                        checked_d[i] = 1'b0;
                        visit_d[i]   = '0;
                    end
                end
                if (start)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (ret_valid && hit) begin
                    for (int i = 0; i < NCHK; i++) begin
                        if (IW'(i) == hitIdx) begin
                            visit_d[i] = visitInc;
                            if (doCheck)
                                checked_d[i] = 1'b1;
                        end
                    end
                    if (isHang) begin
                        state_d   = S_HUNG;
                        hangIdx_d = hitIdx;
                    end else if (doCheck) begin
                        if (checkPass) begin
                            pass_d = (pass_q == {CNT_W{1'b1}}) ? pass_q : pass_q + CNT_W'(1);
                        end else begin
                            fail_d = (fail_q == {CNT_W{1'b1}}) ? fail_q : fail_q + CNT_W'(1);
                            if (!ffValid_q) begin
                                ffValid_d = 1'b1;
                                ffIdx_d   = hitIdx;
                            end
                        end
                    end
                end
                if (state_d != S_HUNG && allChecked)
                    state_d = S_DONE;
            end
            default: ;
        endcase
    end

    // Control state, flags and counters; reset wipes the table back to all-disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CFG;
            pass_q    <= '0;
            fail_q    <= '0;
            ffValid_q <= 1'b0;
            ffIdx_q   <= '0;
            hangIdx_q <= '0;
            for (int i = 0; i < NCHK; i++) begin
                mode_q[i]    <= M_OFF;
                checked_q[i] <= 1'b0;
                visit_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffValid_q <= ffValid_d;
            ffIdx_q   <= ffIdx_d;
            hangIdx_q <= hangIdx_d;
            for (int i = 0; i < NCHK; i++) begin
                mode_q[i]    <= mode_d[i];
                checked_q[i] <= checked_d[i];
                visit_q[i]   <= visit_d[i];
            end
        end
    end

    // Checkpoint payload needs no reset: a disabled mode makes the contents irrelevant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCHK; i++) begin
            if (!reset && state_q == S_CFG && cfg_we && IW'(i) == cfg_idx) begin
                pc_q[i]     <= cfg_pc;
                expect_q[i] <= cfg_expect;
                addr_q[i]   <= cfg_addr;
            end
        end
    end

    assign running          = (state_q == S_RUN);
    assign done             = (state_q == S_DONE);
    assign hung             = (state_q == S_HUNG);
    assign pass_cnt         = pass_q;
    assign fail_cnt         = fail_q;
    assign first_fail_valid = ffValid_q;
    assign first_fail_idx   = ffIdx_q;
    assign hang_idx         = hangIdx_q;

endmodule
